lcd_bus_monitor: RTL

LCD-side receiver for the 4-bit HD44780-style write bus driven by the LCD controller. It samples Enable, RS, RW and DB[3:0] on the system clock and performs the 8-bit to 4-bit mode switch. It reassembles nibbles into bytes, decodes commands, and keeps a 32-character display buffer, an address counter and a busy model. It is used as an on-chip or bench checker, and as the responder end of the controller's LCD interface.

---
 rtl/lcd_bus_monitor.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_monitor.sv
// Receiver/checker for the 4-bit HD44780 write bus: rebuilds bytes, decodes commands, mirrors 32-char DDRAM.
// Latency: byte effects land two clocks after the first clock that samples E low; read port is one clock.
// Backpressure: none; strobes arriving while the busy model is active are still processed but flag oError.
module lcd_bus_monitor #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RS,
  input  logic       iLCD_RW,
  input  logic [3:0] iLCD_Data,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdData,
  output logic       oByte_Valid,
  output logic [7:0] oByte,
  output logic       oByte_RS,
  output logic       oMode4,
  output logic       oBusy,
  output logic [6:0] oAddr,
  output logic       oDisplayOn,
  output logic       oError
);

  localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  typedef enum logic {PH_HI, PH_LO} phase_e;

  // input synchroniser / edge-detect stage
  logic       e_s1_q, rs_s1_q, rw_s1_q, e_s2_q;
  logic [3:0] db_s1_q;
  // registered strobe with its RS/DB
  logic       stb_q, stb_rs_q;
  logic [3:0] stb_db_q;

  phase_e           phase_q, phase_d;
  logic [3:0]       hi_q, hi_d;
  logic             hi_rs_q, hi_rs_d;
  logic             mode4_q, mode4_d;
  logic [6:0]       addr_q, addr_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d;
  logic             err_q, err_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_rs_q, byte_rs_d;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_q;
  logic [7:0]       buf_q [32];

  logic       done;
  logic [7:0] cur_byte;
  logic       cur_rs;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic       clr;

  // Address step over the two-line DDRAM map (line 1 0x00-0x27, line 2 0x40-0x67).
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // Sample the bus once, E twice, then register the falling-edge strobe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      e_s1_q   <= 1'b0;
      rs_s1_q  <= 1'b0;
      rw_s1_q  <= 1'b0;
      db_s1_q  <= 4'h0;
      e_s2_q   <= 1'b0;
      stb_q    <= 1'b0;
      stb_rs_q <= 1'b0;
      stb_db_q <= 4'h0;
    end else begin
      e_s1_q   <= iLCD_Enabled;
      rs_s1_q  <= iLCD_RS;
      rw_s1_q  <= iLCD_RW;
      db_s1_q  <= iLCD_Data;
      e_s2_q   <= e_s1_q;
      stb_q    <= e_s2_q & ~e_s1_q & ~rw_s1_q;
      stb_rs_q <= rs_s1_q;
      stb_db_q <= db_s1_q;
    end
  end

  // Nibble assembly, command/data decode and busy model next state.
  always_comb begin
    phase_d   = phase_q;
    hi_d      = hi_q;
    hi_rs_d   = hi_rs_q;
    mode4_d   = mode4_q;
    addr_d    = addr_q;
    id_d      = id_q;
    disp_d    = disp_q;
    err_d     = err_q;
    byte_d    = byte_q;
    byte_rs_d = byte_rs_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    done      = 1'b0;
    cur_byte  = 8'h00;
    cur_rs    = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = 5'd0;
    clr       = 1'b0;

    if (stb_q) begin
      if (cnt_q != '0) err_d = 1'b1;
      if (!mode4_q) begin
        // 8-bit mode: only DB[7:4] are wired, low nibble reads as zero
        done     = 1'b1;
        cur_byte = {stb_db_q, 4'h0};
        cur_rs   = stb_rs_q;
        if (cur_byte == 8'h20) begin
          mode4_d = 1'b1;
          phase_d = PH_HI;
        end
      end else begin
        unique case (phase_q)
          PH_HI: begin
            hi_d    = stb_db_q;
            hi_rs_d = stb_rs_q;
            phase_d = PH_LO;
          end
          PH_LO: begin
            done     = 1'b1;
            cur_byte = {hi_q, stb_db_q};
            cur_rs   = stb_rs_q;
            if (stb_rs_q != hi_rs_q) err_d = 1'b1;
            phase_d  = PH_HI;
          end
          default: phase_d = PH_HI;
        endcase
      end
    end

    if (done) begin
      byte_d    = cur_byte;
      byte_rs_d = cur_rs;
      cnt_d     = BUSY_LOAD;
      if (cur_rs) begin
        if (addr_q[6:4] == 3'b000) begin
          wr_en  = 1'b1;
          wr_idx = {1'b0, addr_q[3:0]};
        end else if (addr_q[6:4] == 3'b100) begin
          wr_en  = 1'b1;
          wr_idx = {1'b1, addr_q[3:0]};
        end
        addr_d = step_addr(addr_q, id_q);
      end else begin
        // highest set bit selects the instruction; CGRAM, function set, shift are no-ops here
        if (cur_byte[7]) begin
          addr_d = cur_byte[6:0];
        end else if (cur_byte[6] || cur_byte[5] || cur_byte[4]) begin
          addr_d = addr_q;
        end else if (cur_byte[3]) begin
          disp_d = cur_byte[2];
        end else if (cur_byte[2]) begin
          id_d = cur_byte[1];
        end else if (cur_byte[1]) begin
          addr_d = 7'h00;
          cnt_d  = CLEAR_LOAD;
        end else if (cur_byte[0]) begin
          clr    = 1'b1;
          addr_d = 7'h00;
          id_d   = 1'b1;
          cnt_d  = CLEAR_LOAD;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase_q   <= PH_HI;
      hi_q      <= 4'h0;
      hi_rs_q   <= 1'b0;
      mode4_q   <= 1'b0;
      addr_q    <= 7'h00;
      id_q      <= 1'b1;
      disp_q    <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= 8'h00;
      byte_rs_q <= 1'b0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      hi_rs_q   <= hi_rs_d;
      mode4_q   <= mode4_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      byte_q    <= byte_d;
      byte_rs_q <= byte_rs_d;
      vld_q     <= done;
      cnt_q     <= cnt_d;
    end
  end

  // Display buffer: clear fills every cell with space in one edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (clr) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (wr_en) begin
      buf_q[wr_idx] <= cur_byte;
    end
  end

  // Registered read port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rd_q <= 8'h20;
    else        rd_q <= buf_q[iRdAddr];
  end

  assign oRdData     = rd_q;
  assign oByte_Valid = vld_q;
  assign oByte       = byte_q;
  assign oByte_RS    = byte_rs_q;
  assign oMode4      = mode4_q;
  assign oBusy       = (cnt_q != '0);
  assign oAddr       = addr_q;
  assign oDisplayOn  = disp_q;
  assign oError      = err_q;

endmodule
